array_os_seq: RTL
=================

ARRAY_OS_SEQ -- requirements
Module: array_os_seq

Interface
REQ-001 SHALL have parameter HEIGHT, default 4: PE rows, one ifm lane per row.
REQ-002 SHALL have parameter WIDTH, default 4: PE columns, one wght lane per column.
REQ-003 SHALL have parameter IWIDTH, default 16: signed operand width.
REQ-004 SHALL have parameter OWIDTH, default 32: signed accumulator width.
REQ-005 SHALL have parameter KMAX, default 256: maximum reduction length per tile.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port start, input, 1: single-cycle tile start request.
REQ-010 SHALL have port k_len, input, $clog2(KMAX+1): reduction length, sampled when start is accepted.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have port in_valid, input, 1: operand beat valid.
REQ-013 SHALL have port in_ready, output, 1: operand beat accepted when in_valid and in_ready are both high.
REQ-014 SHALL have port ifm, input, HEIGHT x IWIDTH signed: one operand per row.
REQ-015 SHALL have port wght, input, WIDTH x IWIDTH signed: one operand per column.
REQ-016 SHALL have port out_valid, input/output pair: out_valid output 1, out_ready input 1; a result row transfers when both are high.
REQ-017 SHALL have port ofm, output, WIDTH x OWIDTH signed: accumulators of the current drain row.
REQ-018 SHALL have port out_row, output, $clog2(HEIGHT): index of the row on ofm.
REQ-019 SHALL have port done, output, 1: one-cycle pulse at tile completion.

Function
REQ-020 SHALL implement an output-stationary HEIGHTxWIDTH MAC array; ifm moves right one PE per cycle, wght moves down one PE per cycle, each carrying a valid bit.
REQ-021 SHALL skew inputs so beat t reaches PE(h,w) at cycle t+h+w for both operands; bubbles (in_valid low) propagate with valid=0 and are not accumulated.
REQ-022 SHALL accumulate: the full 2*IWIDTH signed product, sign-extended to OWIDTH, is added to acc(h,w); the sum wraps modulo 2^OWIDTH without saturation.
REQ-023 SHALL use FSM IDLE->LOAD->FLUSH->DRAIN->IDLE.
REQ-024 IDLE: start accepted; all accumulators and skew valids cleared next cycle; k_len latched, values above KMAX clamped to KMAX; next state is LOAD, or FLUSH when k_len=0.
REQ-025 LOAD: in_ready=1 and combinational from state only; the beat counter advances per accepted beat; after beat k_len is accepted, next state is FLUSH.
REQ-026 FLUSH: SHALL last exactly HEIGHT+WIDTH-1 cycles with in_ready=0, then go to DRAIN.
REQ-027 DRAIN: out_valid=1; rows are presented in order 0..HEIGHT-1; ofm and out_row are held stable while out_ready=0.
REQ-028 SHALL pulse done in the cycle after the handshake of row HEIGHT-1; the state is IDLE in that same cycle.
REQ-029 SHALL ignore start when not IDLE; a start in the done cycle is accepted.
REQ-030 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-031 While rst is high, SHALL hold the state in IDLE, with all counters, accumulators, skew registers and valid bits at zero.
REQ-032 While rst is high, SHALL hold outputs at busy=0, in_ready=0, out_valid=0, done=0, ofm=0, out_row=0.
REQ-033 Assertion of rst mid-tile SHALL abandon the tile; no done pulse and no partial output are produced after release.

Structure
REQ-034 SHALL place the FSM state enum and the product/accumulate width helpers in shared package array_pkg.
REQ-035 SHALL use one sub-module, pe_os, which holds the ifm/wght/valid forwarding registers and the accumulator, with a synchronous clear.

Verification
REQ-036 Identity test: 4x4, k_len=4, ifm=I rows, wght=B columns, in_valid held high, out_ready=1 -> rows 0..3 equal B transposed appropriately; first out_valid 7 cycles after the last beat; done pulse follows row 3.
REQ-037 Bubble test: k_len=3, in_valid toggled 1,0,1,0,1 with ifm all 2 and wght all 3 -> every ofm equals 18.
REQ-038 Wrap test: OWIDTH=32, k_len=2, ifm=-32768, wght=-32768 -> each acc equals 0x8000_0000 (wrapped, negative).
REQ-039 Back-pressure test: out_ready low for 5 cycles during row 1 -> ofm and out_row=1 stay stable; total 4 handshakes; single done pulse.
REQ-040 Edge test: k_len=0 -> all rows 0; a start during DRAIN is ignored; k_len=300 with KMAX=256 -> exactly 256 beats accepted.
REQ-041 Reset test: rst asserted in LOAD after 2 beats -> all outputs 0 immediately; after release, a new tile with k_len=1, ifm=1, wght=5 yields all 5.

Source files
------------

// File: rtl/array_os_seq_pkg.sv
// array_pkg: shared FSM state type and width helpers for the output-stationary array
package array_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

    function automatic int prod_w(input int iw);
        return 2 * iw;
    endfunction

    function automatic int max_w(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/array_os_seq_if.sv
// array_os_seq_if: control, operand and result handshake bundle of the MAC array
interface array_os_seq_if #(
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32,
    parameter int KMAX   = 256
);
    logic                             start;
    logic [$clog2(KMAX+1)-1:0]        k_len;
    logic                             busy;
    logic                             in_valid;
    logic                             in_ready;
    logic [HEIGHT-1:0][IWIDTH-1:0]    ifm;
    logic [WIDTH-1:0][IWIDTH-1:0]     wght;
    logic                             out_valid;
    logic                             out_ready;
    logic [WIDTH-1:0][OWIDTH-1:0]     ofm;
    logic [$clog2(HEIGHT)-1:0]        out_row;
    logic                             done;

    modport master (
        output start, k_len, in_valid, ifm, wght, out_ready,
        input  busy, in_ready, out_valid, ofm, out_row, done
    );

    modport slave (
        input  start, k_len, in_valid, ifm, wght, out_ready,
        output busy, in_ready, out_valid, ofm, out_row, done
    );
endinterface

// File: rtl/array_os_seq_pe_os.sv
// pe_os: one MAC cell forwarding ifm right and wght down, accumulating aligned valid pairs
module pe_os
    import array_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [IWIDTH-1:0] a_i,
    input  logic              av_i,
    input  logic [IWIDTH-1:0] b_i,
    input  logic              bv_i,
    output logic [IWIDTH-1:0] a_o,
    output logic              av_o,
    output logic [IWIDTH-1:0] b_o,
    output logic              bv_o,
    output logic [OWIDTH-1:0] acc_o
);
    localparam int PW = prod_w(IWIDTH);

    logic signed [PW-1:0]     prod;
    logic signed [OWIDTH-1:0] acc_q;
    logic [IWIDTH-1:0]        a_q, b_q;
    logic                     av_q, bv_q;

    assign prod  = $signed(a_i) * $signed(b_i);
    assign a_o   = a_q;
    assign av_o  = av_q;
    assign b_o   = b_q;
    assign bv_o  = bv_q;
    assign acc_o = acc_q;

    // forward operands one hop and add the sign-extended product, wrapping on overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            av_q  <= 1'b0;
            bv_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            av_q  <= av_i && !clr;
            bv_q  <= bv_i && !clr;
            if (clr)
                acc_q <= '0;
            else if (av_i && bv_i)
                acc_q <= acc_q + OWIDTH'(prod);
        end
    end
endmodule

// File: rtl/array_os_seq.sv
// array_os_seq: output-stationary HEIGHTxWIDTH MAC array with load/flush/drain sequencing
module array_os_seq
    import array_pkg::*;
#(
    parameter int HEIGHT = 4,
    parameter int WIDTH  = 4,
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32,
    parameter int KMAX   = 256
) (
    input logic           clk,
    input logic           rst,
    array_os_seq_if.slave bus
);
    localparam int KW = $clog2(KMAX+1);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = max_w(KW, $clog2(HEIGHT+WIDTH));

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, k_q, k_d;
    logic              done_q, done_d;
    logic              clr, beat;
    logic [RW-1:0]     row;

    logic [IWIDTH-1:0] a_e  [HEIGHT][WIDTH+1];
    logic              av_e [HEIGHT][WIDTH+1];
    logic [IWIDTH-1:0] b_s  [HEIGHT+1][WIDTH];
    logic              bv_s [HEIGHT+1][WIDTH];
    logic [OWIDTH-1:0] acc  [HEIGHT][WIDTH];

    // one counter serves as beat count in LOAD, cycle count in FLUSH and row index in DRAIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                clr     = 1'b1;
                cnt_d   = '0;
                k_d     = (bus.k_len > KW'(KMAX)) ? CW'(KMAX) : CW'(bus.k_len);
                state_d = (bus.k_len == '0) ? FLUSH : LOAD;
            end
            LOAD: if (bus.in_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == k_q) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(HEIGHT+WIDTH-2)) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (bus.out_ready) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(HEIGHT-1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sequencer state, counters and the registered completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    assign beat          = bus.in_valid && state_q == LOAD;
    assign row           = RW'(cnt_q);
    assign bus.busy      = state_q != IDLE;
    assign bus.in_ready  = state_q == LOAD;
    assign bus.out_valid = state_q == DRAIN;
    assign bus.done      = done_q;
    assign bus.out_row   = bus.out_valid ? row : '0;

    for (genvar w = 0; w < WIDTH; w++) begin : g_ofm
        assign bus.ofm[w] = bus.out_valid ? acc[row][w] : '0;
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        if (h == 0) begin : g_direct
            assign a_e[0][0]  = bus.ifm[0];
            assign av_e[0][0] = beat;
        end else begin : g_skew
            logic [IWIDTH-1:0] d_q [h];
            logic              v_q [h];
            // delay row h by h cycles so its beat meets the matching wght beat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < h; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= bus.ifm[h];
                    v_q[0] <= beat;
                    for (int i = 1; i < h; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1] && !clr;
                    end
                end
            end
            assign a_e[h][0]  = d_q[h-1];
            assign av_e[h][0] = v_q[h-1];
        end
    end

    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        if (w == 0) begin : g_direct
            assign b_s[0][0]  = bus.wght[0];
            assign bv_s[0][0] = beat;
        end else begin : g_skew
            logic [IWIDTH-1:0] d_q [w];
            logic              v_q [w];
            // delay column w by w cycles so its beat meets the matching ifm beat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < w; i++) begin
                        d_q[i] <= '0;
                        v_q[i] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= bus.wght[w];
                    v_q[0] <= beat;
                    for (int i = 1; i < w; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1] && !clr;
                    end
                end
            end
            assign b_s[0][w]  = d_q[w-1];
            assign bv_s[0][w] = v_q[w-1];
        end
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_pe_r
        for (genvar w = 0; w < WIDTH; w++) begin : g_pe_c
            pe_os #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .a_i   (a_e[h][w]),
                .av_i  (av_e[h][w]),
                .b_i   (b_s[h][w]),
                .bv_i  (bv_s[h][w]),
                .a_o   (a_e[h][w+1]),
                .av_o  (av_e[h][w+1]),
                .b_o   (b_s[h+1][w]),
                .bv_o  (bv_s[h+1][w]),
                .acc_o (acc[h][w])
            );
        end
    end
endmodule
